// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline sequencing controller
package pipe_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      REDIRECT = 2'd2
   } ctrl_state_e;

   localparam logic [1:0] PCSRC_SEQ = 2'd0;
   localparam logic [1:0] PCSRC_BR  = 2'd1;
   localparam logic [1:0] PCSRC_JMP = 2'd2;

endpackage

// File: rtl/hazard_load_use.sv
// rtl/hazard_load_use.sv - load-use comparator between the load in EX and the consumer in ID
module hazard_load_use
   import pipe_ctrl_pkg::*;
(
   input  logic             ex_mem_read_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_uses_rt_i,
   output logic             lu_o
);

   // $zero is never written, so a load targeting it cannot create a dependency
   assign lu_o = ex_mem_read_i && (ex_rt_i != '0) &&
                 ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hold/flush sequencing for the 5-stage pipeline
// Optional performance counters under HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] ID_Rs,
   input  logic [REG_W-1:0] ID_Rt,
   input  logic             ID_UsesRt,
   input  logic             EX_MemRead,
   input  logic [REG_W-1:0] EX_Rt,
   input  logic             MEM_Branch,
   input  logic             MEM_zero,
   input  logic             MEM_Jump,
   input  logic             MEM_MemRead,
   input  logic             MEM_MemWrite,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             exmem_flush,
   output logic             memwb_bubble,
   output logic             dmem_req,
   output logic             timeout_err
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   localparam int             CW      = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

   ctrl_state_e   state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;
   logic          err_q, err_d;

   logic mem_op, taken, lu, mem_stall;

   assign mem_op    = MEM_MemRead | MEM_MemWrite;
   assign taken     = (MEM_Branch & MEM_zero) | MEM_Jump;
   assign mem_stall = mem_op & ~dmem_ready;

   hazard_load_use u_lu (
      .ex_mem_read_i (EX_MemRead),
      .ex_rt_i       (EX_Rt),
      .id_rs_i       (ID_Rs),
      .id_rt_i       (ID_Rt),
      .id_uses_rt_i  (ID_UsesRt),
      .lu_o          (lu)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d = MEM_WAIT;
               wait_d  = CW'(1);
            end else if (taken) begin
               state_d = REDIRECT;
            end
         end
         REDIRECT: begin
            if (mem_stall) begin
               state_d = MEM_WAIT;
               wait_d  = CW'(1);
            end else begin
               state_d = RUN;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q != MAX_CNT) begin
               wait_d = wait_q + CW'(1);
            end
         end
         default: state_d = RUN;
      endcase
      // the access keeps waiting after the budget is exhausted; only the flag records it
      if (wait_d == MAX_CNT) err_d = 1'b1;
   end

   always_comb begin
      pc_write     = 1'b1;
      pc_src       = PCSRC_SEQ;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_flush   = 1'b0;
      exmem_write  = 1'b1;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;
      dmem_req     = 1'b0;
      case (state_q)
         RUN, REDIRECT: begin
            dmem_req = mem_op;
            if (mem_stall) begin
               pc_write     = 1'b0;
               ifid_write   = 1'b0;
               idex_write   = 1'b0;
               exmem_write  = 1'b0;
               memwb_bubble = 1'b1;
            end else if (state_q == RUN) begin
               // REDIRECT ignores taken/lu: the younger stages hold the squashed path
               if (taken) begin
                  pc_src      = MEM_Jump ? PCSRC_JMP : PCSRC_BR;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
               end else if (lu) begin
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  idex_flush = 1'b1;
               end
            end
         end
         MEM_WAIT: begin
            dmem_req = 1'b1;
            if (!dmem_ready) begin
               pc_write     = 1'b0;
               ifid_write   = 1'b0;
               idex_write   = 1'b0;
               exmem_write  = 1'b0;
               memwb_bubble = 1'b1;
            end
         end
         default: ;
      endcase
      if (rst) begin
         pc_write     = 1'b0;
         pc_src       = PCSRC_SEQ;
         ifid_write   = 1'b0;
         ifid_flush   = 1'b1;
         idex_write   = 1'b0;
         idex_flush   = 1'b1;
         exmem_write  = 1'b0;
         exmem_flush  = 1'b1;
         memwb_bubble = 1'b1;
         dmem_req     = 1'b0;
      end
   end

   assign timeout_err = err_q;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if ((state_q != REDIRECT) && (state_d == REDIRECT) && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ID_Rs, ID_Rt, EX_Rt;
   logic       ID_UsesRt, EX_MemRead, MEM_Branch, MEM_zero, MEM_Jump;
   logic       MEM_MemRead, MEM_MemWrite, dmem_ready;
   logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
   logic       exmem_write, exmem_flush, memwb_bubble, dmem_req, timeout_err;
   logic [1:0] pc_src;
   logic [10:0] outs;

   int n_cmp = 0;
   int n_bad = 0;

   // {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush, memwb_bubble, dmem_req}
   localparam logic [10:0] O_DEF  = 11'b1_00_1_0_1_0_1_0_0_0;
   localparam logic [10:0] O_DREQ = 11'b1_00_1_0_1_0_1_0_0_1;
   localparam logic [10:0] O_LU   = 11'b0_00_0_0_1_1_1_0_0_0;
   localparam logic [10:0] O_BR   = 11'b1_01_1_1_1_1_1_1_0_0;
   localparam logic [10:0] O_JMP  = 11'b1_10_1_1_1_1_1_1_0_0;
   localparam logic [10:0] O_WAIT = 11'b0_00_0_0_0_0_0_0_1_1;
   localparam logic [10:0] O_RST  = 11'b0_00_0_1_0_1_0_1_1_0;

   pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
      .MEM_Branch(MEM_Branch), .MEM_zero(MEM_zero), .MEM_Jump(MEM_Jump),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
      .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble), .dmem_req(dmem_req),
      .timeout_err(timeout_err)
   );

   assign outs = {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush,
                  exmem_write, exmem_flush, memwb_bubble, dmem_req};

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [4:0] rs, rt, ex_rt;
      logic       uses_rt, ex_mr, br, zero, jmp, mrd, mwr, rdy;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(string name, logic [4:0] rs, logic [4:0] rt, logic uses_rt,
                               logic ex_mr, logic [4:0] ex_rt, logic br, logic zero, logic jmp,
                               logic mrd, logic mwr, logic rdy, logic [10:0] exp);
      vec_t v;
      v.name = name; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.ex_mr = ex_mr;
      v.ex_rt = ex_rt; v.br = br; v.zero = zero; v.jmp = jmp; v.mrd = mrd; v.mwr = mwr;
      v.rdy = rdy; v.exp = exp;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      ID_Rs = v.rs; ID_Rt = v.rt; ID_UsesRt = v.uses_rt; EX_MemRead = v.ex_mr; EX_Rt = v.ex_rt;
      MEM_Branch = v.br; MEM_zero = v.zero; MEM_Jump = v.jmp;
      MEM_MemRead = v.mrd; MEM_MemWrite = v.mwr; dmem_ready = v.rdy;
   endtask

   task automatic idle_in();
      apply(mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF));
   endtask

   task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   // inputs change 1 time unit after the edge and outputs are sampled one unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      vecs[0]  = mk("idle",          5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF);
      vecs[1]  = mk("lu_rs",         5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU);
      vecs[2]  = mk("lu_zero_reg",   5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF);
      vecs[3]  = mk("lu_rt_used",    5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU);
      vecs[4]  = mk("lu_rt_unused",  5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF);
      vecs[5]  = mk("no_load",       5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF);
      vecs[6]  = mk("br_taken",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_BR);
      vecs[7]  = mk("br_not_taken",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF);
      vecs[8]  = mk("jmp_and_br",    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_JMP);
      vecs[9]  = mk("ld_not_ready",  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_WAIT);
      vecs[10] = mk("ld_ready",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_DREQ);
      vecs[11] = mk("wait_beats_all",5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, O_WAIT);
      vecs[12] = mk("redir_beats_lu",5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_BR);

      tick();
      apply(vecs[9]);
      #1;
      check("reset_outputs", outs, O_RST);
      check1("reset_timeout", timeout_err, 1'b0);

      for (int i = 0; i < 13; i++) begin
         rst = 1'b1;
         idle_in();
         tick();
         rst = 1'b0;
         apply(vecs[i]);
         #1;
         check(vecs[i].name, outs, vecs[i].exp);
      end

      // load-use bubble lasts exactly one cycle
      do_reset();
      apply(vecs[1]);
      #1;
      check("seq_lu_c0", outs, O_LU);
      tick();
      EX_MemRead = 1'b0;
      #1;
      check("seq_lu_c1", outs, O_DEF);

      // taken branch, then REDIRECT ignores a load-use, then RUN honours it again
      do_reset();
      apply(vecs[6]);
      #1;
      check("seq_br_c0", outs, O_BR);
      tick();
      apply(vecs[1]);
      #1;
      check("seq_redirect_no_lu", outs, O_DEF);
      tick();
      #1;
      check("seq_run_after_redirect", outs, O_LU);

      // memory wait: three not-ready cycles then release
      do_reset();
      apply(vecs[9]);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("seq_wait_c%0d", c), outs, O_WAIT);
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      check("seq_wait_release", outs, O_DREQ);
      tick();
      idle_in();
      #1;
      check("seq_after_release", outs, O_DEF);
      check1("seq_wait_no_timeout", timeout_err, 1'b0);

      // timeout with MAX_WAIT=4: flag appears in the fifth not-ready cycle
      do_reset();
      apply(vecs[9]);
      for (int c = 0; c < 6; c++) begin
         #1;
         check1($sformatf("seq_to_c%0d", c), timeout_err, c >= 4);
         check($sformatf("seq_to_out_c%0d", c), outs, O_WAIT);
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      check("seq_to_release", outs, O_DREQ);
      tick();
      idle_in();
      tick();
      check1("seq_to_sticky", timeout_err, 1'b1);

      // reset while waiting abandons the access and clears the flag
      apply(vecs[9]);
      tick();
      #1;
      check("seq_rw_waiting", outs, O_WAIT);
      rst = 1'b1;
      #1;
      check("seq_rw_during_rst", outs, O_RST);
      tick();
      rst = 1'b0;
      MEM_MemRead = 1'b0;
      #1;
      check("seq_rw_run", outs, O_DEF);
      check1("seq_rw_timeout_clr", timeout_err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
